// File: rtl/jtbubl_pal_dma_if.sv
// Palette DMA bus bundle: source RAM read port, CPU palette access
// and the muxed palette port toward the colour mixer.
`timescale 1ns/1ps

interface jtbubl_pal_dma_if #(
    parameter int AW = 9
);
    logic          src_cs;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data;

    logic          cpu_cs;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;

    logic          pal_cs;
    logic          pal_rnw;
    logic [AW-1:0] pal_addr;
    logic [7:0]    pal_din;

    modport master (
        output src_cs,
        output src_addr,
        input  src_data,
        input  cpu_cs,
        input  cpu_rnw,
        input  cpu_addr,
        input  cpu_dout,
        output pal_cs,
        output pal_rnw,
        output pal_addr,
        output pal_din
    );

    modport slave (
        input  src_cs,
        input  src_addr,
        output src_data,
        output cpu_cs,
        output cpu_rnw,
        output cpu_addr,
        output cpu_dout,
        input  pal_cs,
        input  pal_rnw,
        input  pal_addr,
        input  pal_din
    );
endinterface

// File: rtl/jtbubl_pal_dma.sv
// Copies 2^AW bytes from source RAM into the palette during vblank,
// with the CPU always taking priority on the palette port.
`timescale 1ns/1ps

module jtbubl_pal_dma #(
    parameter int AW = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic LVBL,
    input  logic start,
    output logic busy,
    output logic done,
    jtbubl_pal_dma_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RD,
        CAP,
        WR
    } state_t;

    localparam logic [AW-1:0] LAST = '1;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [7:0]    data_r;
    logic          pending;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_din;
    logic          dma_wr;

    // A DMA write only happens when the CPU is off the port in vblank
    assign dma_wr = (state == WR) && !bus.cpu_cs && !LVBL;

    assign bus.src_cs   = (state == RD);
    assign bus.src_addr = cnt;

    // Copy sequencer: one byte per RD/CAP/WR round, requests merged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            data_r    <= 8'd0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            last_addr <= '0;
            last_din  <= 8'd0;
        end else begin
            done <= 1'b0;
            if (start && state != IDLE) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                ARM: begin
                    if (!LVBL) begin
                        state <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    data_r <= bus.src_data;
                    state  <= WR;
                end
                WR: begin
                    if (dma_wr) begin
                        last_addr <= cnt;
                        last_din  <= data_r;
                        if (cnt == LAST) begin
                            cnt  <= '0;
                            done <= 1'b1;
                            if (pending || start) begin
                                state   <= ARM;
                                pending <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= LVBL ? ARM : RD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Palette port mux: CPU first, then DMA, else park on last DMA values
    always_comb begin
        bus.pal_cs   = 1'b0;
        bus.pal_rnw  = 1'b1;
        bus.pal_addr = last_addr;
        bus.pal_din  = last_din;
        if (bus.cpu_cs) begin
            bus.pal_cs   = 1'b1;
            bus.pal_rnw  = bus.cpu_rnw;
            bus.pal_addr = bus.cpu_addr;
            bus.pal_din  = bus.cpu_dout;
        end else if (dma_wr) begin
            bus.pal_cs   = 1'b1;
            bus.pal_rnw  = 1'b0;
            bus.pal_addr = cnt;
            bus.pal_din  = data_r;
        end
    end

endmodule

// File: tb/tb_jtbubl_pal_dma.sv
// Bench for jtbubl_pal_dma: source RAM and palette models plus an
// expected write stream of whole 0..N-1 copies.
`timescale 1ns/1ps

module tb_jtbubl_pal_dma;

    localparam int AW = 4;
    localparam int N  = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic LVBL  = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    jtbubl_pal_dma_if #(.AW(AW)) bus ();

    jtbubl_pal_dma #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .LVBL  (LVBL),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] src_mem [N];
    logic [7:0] pal_mem [N];

    int exp_addr  = 0;
    int dma_wr_n  = 0;
    int done_n    = 0;
    int first_rd  = -1;
    int first_wr  = -1;
    int last_wr   = -1;
    int done_cyc  = -1;
    bit prev_done = 1'b0;
    bit rand_cpu  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM: data one clock after the read strobe
    always @(posedge clk) begin
        if (!rst_n) bus.src_data <= 8'd0;
        else if (bus.src_cs) bus.src_data <= src_mem[bus.src_addr];
    end

    // Palette port monitor and reference write stream
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_src_cs", bus.src_cs, 0);
            chk("rst_pal_cs", bus.pal_cs, bus.cpu_cs);
        end
        if (bus.cpu_cs) begin
            chk("cpu_pal_cs", bus.pal_cs, 1);
            chk("cpu_pal_rnw", bus.pal_rnw, bus.cpu_rnw);
            chk("cpu_pal_addr", bus.pal_addr, bus.cpu_addr);
            chk("cpu_pal_din", bus.pal_din, bus.cpu_dout);
            if (!bus.cpu_rnw) pal_mem[bus.cpu_addr] = bus.cpu_dout;
        end else if (bus.pal_cs) begin
            chk("dma_wr_lvbl", LVBL, 0);
            chk("dma_wr_rnw", bus.pal_rnw, 0);
            chk("dma_wr_addr", bus.pal_addr, exp_addr);
            chk("dma_wr_data", bus.pal_din, src_mem[exp_addr]);
            pal_mem[bus.pal_addr] = bus.pal_din;
            if (dma_wr_n == 0) first_wr = cyc;
            last_wr = cyc;
            dma_wr_n++;
            exp_addr = (exp_addr + 1) % N;
        end else begin
            chk("idle_pal_rnw", bus.pal_rnw, 1);
        end
        if (bus.src_cs && first_rd < 0) first_rd = cyc;
        if (done) begin
            chk("done_single", prev_done, 0);
            done_n++;
            done_cyc = cyc;
        end
        prev_done = done;
    end

    task automatic clr();
        dma_wr_n = 0;
        done_n   = 0;
        first_rd = -1;
        first_wr = -1;
        last_wr  = -1;
        done_cyc = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_cpu) begin
                bus.cpu_cs   = ($urandom_range(0, 3) == 0);
                bus.cpu_rnw  = 1'($urandom_range(0, 1));
                bus.cpu_addr = AW'($urandom_range(0, N - 1));
                bus.cpu_dout = 8'($urandom);
            end
        end
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_n < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("done_timeout", 32'(done_n >= n), 1);
    endtask

    task automatic wait_rd(input int a, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.src_cs && bus.src_addr == AW'(a)) && k < budget);
        chk("rd_timeout", 32'(k < budget), 1);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) src_mem[i] = 8'(8'hA0 + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) src_mem[i] = 8'($urandom);
    endtask

    task automatic chk_pal(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < N; i++)
            if (pal_mem[i] !== src_mem[i]) errs++;
        chk(tag, errs, 0);
    endtask

    initial begin
        int s;
        int k;
        for (int i = 0; i < N; i++) pal_mem[i] = 8'd0;
        fill_ramp();
        bus.cpu_cs   = 1'b1;
        bus.cpu_rnw  = 1'b0;
        bus.cpu_addr = 4'd3;
        bus.cpu_dout = 8'h55;

        // reset state with the CPU mux live
        tick(2);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_src_cs", bus.src_cs, 0);
        chk("reset_pal_cs", bus.pal_cs, 1);
        chk("reset_pal_addr", bus.pal_addr, 3);
        chk("reset_pal_din", bus.pal_din, 8'h55);
        bus.cpu_cs = 1'b0;
        #1;
        chk("reset_pal_idle", bus.pal_cs, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("idle_busy", busy, 0);

        // basic copy and latency
        clr();
        pulse_start(s);
        chk("busy_next", busy, 1);
        wait_done(1, 200);
        chk("t1_first_rd", first_rd, s + 2);
        chk("t1_first_wr", first_wr, first_rd + 2);
        chk("t1_span", last_wr - first_rd + 1, 3 * N);
        chk("t1_done_cyc", done_cyc, last_wr + 1);
        tick(5);
        chk("t1_writes", dma_wr_n, N);
        chk("t1_dones", done_n, 1);
        chk("t1_busy_end", busy, 0);
        chk_pal("t1_pal");

        // CPU priority over the write of byte 7
        clr();
        pulse_start(s);
        wait_rd(7, 200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_cs   = 1'b1;
        bus.cpu_rnw  = 1'b0;
        bus.cpu_addr = 4'd5;
        bus.cpu_dout = 8'h3C;
        chk("t2_wr_before", dma_wr_n, 7);
        tick(4);
        bus.cpu_cs = 1'b0;
        @(negedge clk);
        chk("t2_dma_cs", bus.pal_cs, 1);
        chk("t2_dma_addr", bus.pal_addr, 7);
        chk("t2_dma_din", bus.pal_din, 8'hA7);
        wait_done(1, 200);
        tick(2);
        chk("t2_writes", dma_wr_n, N);
        chk("t2_pal7", pal_mem[7], 8'hA7);
        chk("t2_pal5", pal_mem[5], 8'h3C);

        // vblank ends at byte 9
        fill_rand();
        clr();
        pulse_start(s);
        wait_rd(9, 200);
        @(posedge clk); #1;
        LVBL = 1'b1;
        k = 0;
        repeat (20) begin
            tick(1);
            if (busy !== 1'b1) k++;
        end
        chk("t3_busy_held", k, 0);
        chk("t3_writes_held", dma_wr_n, 9);
        LVBL = 1'b0;
        wait_done(1, 200);
        tick(2);
        chk("t3_writes", dma_wr_n, N);
        chk("t3_dones", done_n, 1);
        chk_pal("t3_pal");

        // merged extra requests under random CPU traffic
        fill_rand();
        clr();
        rand_cpu = 1'b1;
        pulse_start(s);
        tick($urandom_range(5, 20));
        pulse_start(s);
        tick($urandom_range(1, 8));
        pulse_start(s);
        tick(1);
        pulse_start(s);
        wait_done(2, 800);
        rand_cpu   = 1'b0;
        bus.cpu_cs = 1'b0;
        tick(80);
        chk("t4_dones", done_n, 2);
        chk("t4_writes", dma_wr_n, 2 * N);
        chk("t4_busy_end", busy, 0);

        // request on the final write cycle
        fill_rand();
        clr();
        pulse_start(s);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.pal_cs && !bus.cpu_cs && bus.pal_addr == 4'd15)
                   && k < 200);
        chk("t5_last_timeout", 32'(k < 200), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, 300);
        tick(60);
        chk("t5_dones", done_n, 2);
        chk("t5_writes", dma_wr_n, 2 * N);
        chk("t5_busy_end", busy, 0);

        // reset in the middle of a copy
        fill_rand();
        clr();
        pulse_start(s);
        wait_rd(6, 200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_src_cs", bus.src_cs, 0);
        chk("t6_pal_cs", bus.pal_cs, 0);
        tick(3);
        rst_n = 1'b1;
        tick(30);
        chk("t6_writes", dma_wr_n, 6);
        chk("t6_dones", done_n, 0);
        chk("t6_busy_after", busy, 0);
        clr();
        pulse_start(s);
        wait_done(1, 200);
        tick(2);
        chk("t6_restart", dma_wr_n, N);
        chk_pal("t6_pal");

        // request while out of vblank for 100 cycles
        fill_rand();
        LVBL = 1'b1;
        clr();
        pulse_start(s);
        k = 0;
        repeat (100) begin
            tick(1);
            if (busy !== 1'b1 || bus.src_cs !== 1'b0) k++;
        end
        chk("t7_wait", k, 0);
        chk("t7_no_wr", dma_wr_n, 0);
        LVBL = 1'b0;
        wait_done(1, 200);
        tick(2);
        chk("t7_writes", dma_wr_n, N);
        chk("t7_busy_end", busy, 0);
        chk_pal("t7_pal");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
